// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle sequencer and its decoder.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_DONE
    } state_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL,
        CL_ADDI,
        CL_ADDS,
        CL_SUBS,
        CL_AND,
        CL_EOR,
        CL_LDUR,
        CL_STUR,
        CL_CBZ
    } iclass_t;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef struct packed {
        iclass_t     cls;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        reg2loc;
        logic        mem_to_reg;
        logic [11:0] imm;
        logic        illegal;
    } ctrl_t;

    // Classes that finish through the register write-back phase straight from EXEC.
    function automatic logic is_alu(input iclass_t cls);
        return (cls == CL_ADDI) || (cls == CL_ADDS) || (cls == CL_SUBS) ||
               (cls == CL_AND)  || (cls == CL_EOR);
    endfunction

endpackage

// File: rtl/dp_decoder.sv
// Combinational LEGv8 subset decoder: instruction word to class and datapath controls.
module dp_decoder
    import dp_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.cls     = CL_ILLEGAL;
        ctrl.illegal = 1'b1;
        if (instr[31:22] == OP_ADDI) begin
            ctrl.cls     = CL_ADDI;
            ctrl.illegal = 1'b0;
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALU_ADD;
            ctrl.imm     = instr[21:10];
            ctrl.reg2loc = 1'b1;
        end else if (instr[31:21] == OP_ADDS || instr[31:21] == OP_SUBS) begin
            ctrl.cls     = (instr[31:21] == OP_ADDS) ? CL_ADDS : CL_SUBS;
            ctrl.illegal = 1'b0;
            ctrl.alu_op  = (instr[31:21] == OP_ADDS) ? ALU_ADD : ALU_SUB;
            ctrl.reg2loc = 1'b1;
        end else if (instr[31:21] == OP_AND || instr[31:21] == OP_EOR) begin
            ctrl.cls     = (instr[31:21] == OP_AND) ? CL_AND : CL_EOR;
            ctrl.illegal = 1'b0;
            ctrl.alu_op  = (instr[31:21] == OP_AND) ? ALU_AND : ALU_XOR;
            ctrl.reg2loc = 1'b1;
        end else if ((instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) && !instr[20]) begin
            // Negative offsets fall through to the illegal default.
            ctrl.cls        = (instr[31:21] == OP_LDUR) ? CL_LDUR : CL_STUR;
            ctrl.illegal    = 1'b0;
            ctrl.alu_src    = 1'b1;
            ctrl.alu_op     = ALU_ADD;
            ctrl.imm        = {4'b0, instr[19:12]};
            ctrl.mem_to_reg = (instr[31:21] == OP_LDUR);
            ctrl.reg2loc    = (instr[31:21] == OP_LDUR);
        end else if (instr[31:24] == OP_CBZ) begin
            ctrl.cls     = CL_CBZ;
            ctrl.illegal = 1'b0;
            ctrl.alu_op  = ALU_PASSB;
        end
    end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction, walks DECODE/EXEC/MEM/WB, pulses done.
module dp_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        Zero,
    output logic [4:0]  Rd,
    output logic [4:0]  Rm,
    output logic [4:0]  Rn,
    output logic [11:0] AddI12,
    output logic [2:0]  ALUOp,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        done,
    output logic        branch_taken,
    output logic        illegal,
    output logic        flag_z
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    // Handshake: an instruction transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready is high only in IDLE.
    state_t      state, state_nxt;
    logic [31:0] instr_q;
    logic [3:0]  cnt;
    iclass_t     cls_q;
    logic        illegal_q;
    logic        bt_q;
    ctrl_t       dec;

    dp_decoder u_dec (
        .instr (instr_q),
        .ctrl  (dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            cnt       <= '0;
            cls_q     <= CL_ILLEGAL;
            illegal_q <= 1'b0;
            bt_q      <= 1'b0;
            flag_z    <= 1'b0;
            Rd        <= '0;
            Rn        <= '0;
            Rm        <= '0;
            AddI12    <= '0;
            ALUOp     <= '0;
            Reg2Loc   <= 1'b0;
            ALUSrc    <= 1'b0;
            MemToReg  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        instr_q   <= instr;
                        bt_q      <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    Rd        <= instr_q[4:0];
                    Rn        <= instr_q[9:5];
                    Rm        <= instr_q[20:16];
                    AddI12    <= dec.imm;
                    ALUOp     <= dec.alu_op;
                    Reg2Loc   <= dec.reg2loc;
                    ALUSrc    <= dec.alu_src;
                    MemToReg  <= dec.mem_to_reg;
                    cls_q     <= dec.cls;
                    illegal_q <= dec.illegal;
                    cnt       <= SETTLE_LAST;
                end
                ST_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (cls_q == CL_CBZ) begin
                        bt_q <= Zero;
                    end
                end
                ST_WB: begin
                    if (cls_q == CL_ADDS || cls_q == CL_SUBS) begin
                        flag_z <= Zero;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (in_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = dec.illegal ? ST_DONE : ST_EXEC;
            ST_EXEC: begin
                if (cnt == 4'd0) begin
                    if (is_alu(cls_q))                             state_nxt = ST_WB;
                    else if (cls_q == CL_LDUR || cls_q == CL_STUR) state_nxt = ST_MEM;
                    else                                           state_nxt = ST_DONE;
                end
            end
            ST_MEM:    state_nxt = (cls_q == CL_STUR) ? ST_DONE : ST_WB;
            ST_WB:     state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are gated by reset so an abandoned instruction never writes.
    always_comb begin
        in_ready     = (state == ST_IDLE);
        RegWrite     = reset && (state == ST_WB) && (Rd != 5'd31);
        MemWrite     = reset && (state == ST_MEM) && (cls_q == CL_STUR);
        done         = (state == ST_DONE);
        branch_taken = done && bt_q;
        illegal      = done && illegal_q;
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: vector table plus back-to-back, reset and long-settle sequences.
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iv1 = 1'b0, iv3 = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        use3 = 1'b0;

    logic        rdy_1, rw_1, mw_1, done_1, bt_1, il_1, fz_1, r2l_1, src_1, m2r_1;
    logic        rdy_3, rw_3, mw_3, done_3, bt_3, il_3, fz_3, r2l_3, src_3, m2r_3;
    logic [4:0]  rd_1, rn_1, rm_1, rd_3, rn_3, rm_3;
    logic [11:0] imm_1, imm_3;
    logic [2:0]  op_1, op_3;

    logic        s_rdy, s_rw, s_mw, s_done, s_bt, s_il, s_fz, s_r2l, s_src, s_m2r;
    logic [4:0]  s_rd, s_rn, s_rm;
    logic [11:0] s_imm;
    logic [2:0]  s_op;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dp_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy_1), .instr(instr), .Zero(zero),
        .Rd(rd_1), .Rm(rm_1), .Rn(rn_1), .AddI12(imm_1), .ALUOp(op_1), .Reg2Loc(r2l_1),
        .ALUSrc(src_1), .MemToReg(m2r_1), .RegWrite(rw_1), .MemWrite(mw_1), .done(done_1),
        .branch_taken(bt_1), .illegal(il_1), .flag_z(fz_1)
    );

    dp_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(rdy_3), .instr(instr), .Zero(zero),
        .Rd(rd_3), .Rm(rm_3), .Rn(rn_3), .AddI12(imm_3), .ALUOp(op_3), .Reg2Loc(r2l_3),
        .ALUSrc(src_3), .MemToReg(m2r_3), .RegWrite(rw_3), .MemWrite(mw_3), .done(done_3),
        .branch_taken(bt_3), .illegal(il_3), .flag_z(fz_3)
    );

    always_comb begin
        s_rdy  = use3 ? rdy_3  : rdy_1;
        s_rw   = use3 ? rw_3   : rw_1;
        s_mw   = use3 ? mw_3   : mw_1;
        s_done = use3 ? done_3 : done_1;
        s_bt   = use3 ? bt_3   : bt_1;
        s_il   = use3 ? il_3   : il_1;
        s_fz   = use3 ? fz_3   : fz_1;
        s_r2l  = use3 ? r2l_3  : r2l_1;
        s_src  = use3 ? src_3  : src_1;
        s_m2r  = use3 ? m2r_3  : m2r_1;
        s_rd   = use3 ? rd_3   : rd_1;
        s_rn   = use3 ? rn_3   : rn_1;
        s_rm   = use3 ? rm_3   : rm_1;
        s_imm  = use3 ? imm_3  : imm_1;
        s_op   = use3 ? op_3   : op_1;
    end

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          lat_base;
        logic [2:0]  op;
        logic        src, r2l, m2r;
        logic [11:0] imm;
        logic [4:0]  rd, rn, rm;
        int          rw, mw;
        logic        bt, il, fz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input bit u3, input vec_t v);
        int cyc, rw_n, mw_n, both_n, exp_lat;
        use3  = u3;
        instr = v.instr;
        zero  = v.zero;
        @(negedge clk);
        for (int i = 0; i < 50 && !s_rdy; i++) @(negedge clk);
        chk("ready_wait", 32'(s_rdy), 32'd1);
        if (u3) iv3 = 1'b1; else iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        iv3 = 1'b0;
        cyc = 0; rw_n = 0; mw_n = 0; both_n = 0;
        while (!s_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            rw_n   += int'(s_rw);
            mw_n   += int'(s_mw);
            both_n += int'(s_rw & s_mw);
        end
        exp_lat = v.il ? 2 : v.lat_base + (u3 ? 3 : 1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("regwrite_cycles", 32'(rw_n), 32'(v.rw));
        chk("memwrite_cycles", 32'(mw_n), 32'(v.mw));
        chk("both_strobes", 32'(both_n), 32'd0);
        chk("aluop", 32'(s_op), 32'(v.op));
        chk("alusrc", 32'(s_src), 32'(v.src));
        chk("reg2loc", 32'(s_r2l), 32'(v.r2l));
        chk("memtoreg", 32'(s_m2r), 32'(v.m2r));
        chk("addi12", 32'(s_imm), 32'(v.imm));
        chk("rd", 32'(s_rd), 32'(v.rd));
        chk("rn", 32'(s_rn), 32'(v.rn));
        chk("rm", 32'(s_rm), 32'(v.rm));
        chk("branch_taken", 32'(s_bt), 32'(v.bt));
        chk("illegal", 32'(s_il), 32'(v.il));
        chk("flag_z", 32'(s_fz), 32'(v.fz));
        chk("busy_ready", 32'(s_rdy), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(s_done), 32'd0);
        chk("ready_after", 32'(s_rdy), 32'd1);
    endtask

    vec_t vecs[11];
    vec_t v_subs, v_ldur, v_stur;

    initial begin
        int cyc;
        //           instr         z  lb op      src r2l m2r imm    rd     rn     rm     rw mw bt il fz
        vecs[0]  = '{32'h91001403, 0, 3, 3'b010, 1, 1, 0, 12'd5,  5'd3,  5'd0, 5'd0,  1, 0, 0, 0, 0};
        vecs[1]  = '{32'hEB010022, 1, 3, 3'b011, 0, 1, 0, 12'd0,  5'd2,  5'd1, 5'd1,  1, 0, 0, 0, 1};
        vecs[2]  = '{32'h8A030049, 0, 3, 3'b100, 0, 1, 0, 12'd0,  5'd9,  5'd2, 5'd3,  1, 0, 0, 0, 1};
        vecs[3]  = '{32'hCA03005F, 0, 3, 3'b110, 0, 1, 0, 12'd0,  5'd31, 5'd2, 5'd3,  0, 0, 0, 0, 1};
        vecs[4]  = '{32'hAB030041, 0, 3, 3'b010, 0, 1, 0, 12'd0,  5'd1,  5'd2, 5'd3,  1, 0, 0, 0, 0};
        vecs[5]  = '{32'hF80080A4, 0, 3, 3'b010, 1, 0, 0, 12'd8,  5'd4,  5'd5, 5'd0,  0, 1, 0, 0, 0};
        vecs[6]  = '{32'hF84100A6, 0, 4, 3'b010, 1, 1, 1, 12'd16, 5'd6,  5'd5, 5'd1,  1, 0, 0, 0, 0};
        vecs[7]  = '{32'hB4000007, 1, 2, 3'b000, 0, 0, 0, 12'd0,  5'd7,  5'd0, 5'd0,  0, 0, 1, 0, 0};
        vecs[8]  = '{32'hB4000007, 0, 2, 3'b000, 0, 0, 0, 12'd0,  5'd7,  5'd0, 5'd0,  0, 0, 0, 0, 0};
        vecs[9]  = '{32'h00000000, 0, 0, 3'b000, 0, 0, 0, 12'd0,  5'd0,  5'd0, 5'd0,  0, 0, 0, 1, 0};
        vecs[10] = '{32'hF85000A6, 0, 0, 3'b000, 0, 0, 0, 12'd0,  5'd6,  5'd5, 5'd16, 0, 0, 0, 1, 0};
        v_subs = vecs[1];
        v_ldur = vecs[6];
        v_stur = vecs[5];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy_1), 32'd1);
        chk("rst_strobes", 32'({rw_1, mw_1, done_1, bt_1, il_1}), 32'd0);
        chk("rst_flag_z", 32'(fz_1), 32'd0);
        chk("rst_fields", {rd_1, rn_1, rm_1, op_1, imm_1}, 32'd0);
        chk("rst_selects", 32'({r2l_1, src_1, m2r_1}), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(1'b0, vecs[i]);

        // Back-to-back with in_valid held high
        use3 = 1'b0;
        instr = 32'h91001403;
        zero = 1'b0;
        @(negedge clk);
        iv1 = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done_1 && cyc < 40) begin @(negedge clk); cyc++; end
        chk("b2b_lat1", 32'(cyc), 32'd4);
        @(posedge clk); #1;
        chk("b2b_ready_after_done", 32'(rdy_1), 32'd1);
        @(posedge clk); #1;
        chk("b2b_accepted", 32'(rdy_1), 32'd0);
        iv1 = 1'b0;
        cyc = 0;
        while (!done_1 && cyc < 40) begin @(negedge clk); cyc++; end
        chk("b2b_lat2", 32'(cyc), 32'd4);

        // Reset in EXEC of ADDS X1 after SUBS has set flag_z
        run_vec(1'b0, v_subs);
        instr = 32'hAB030041;
        zero = 1'b1;
        @(negedge clk);
        iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_exec_rw", 32'(rw_1), 32'd0);
        @(posedge clk); #1;
        chk("rst_exec_ready", 32'(rdy_1), 32'd1);
        chk("rst_exec_rw_next", 32'(rw_1), 32'd0);
        chk("rst_exec_flag_z", 32'(fz_1), 32'd0);
        chk("rst_exec_fields", {rd_1, rn_1, rm_1, op_1, done_1}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_exec_rw_after", 32'(rw_1), 32'd0);
        chk("rst_exec_idle", 32'(rdy_1), 32'd1);

        // Long settle instance
        run_vec(1'b1, v_ldur);
        run_vec(1'b1, v_stur);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
